// File: rtl/alu_op_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer_pkg
// Purpose  : Shared definitions for the ALU operation sequencer: default
//            slice width, ALU select width, settle-counter width and the
//            FSM state encodings used by alu_op_sequencer.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package alu_op_sequencer_pkg;

    // Default ALU slice width; commands and results are twice this wide
    localparam int DATA_W_DEF = 8;

    // ALU function-select width
    localparam int ALU_S_W = 3;

    // Settle counter width; supports SETTLE_CYC values up to 15
    localparam int CNT_W = 4;

    // Sequencer FSM state encodings
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PASS_LO = 2'd1;
    localparam logic [1:0] ST_PASS_HI = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

endpackage : alu_op_sequencer_pkg
`default_nettype wire

// File: rtl/alu_pass_timer.sv
`default_nettype none
// ============================================================================
// Module   : alu_pass_timer
// Purpose  : Settle counter for one ALU pass. Counts cycles while enabled
//            and flags the last settle cycle (count == SETTLE_CYC-1). The
//            counter returns to zero on that cycle so a following pass
//            starts with a fresh count.
// Ports    : clk   - clock
//            rst   - synchronous active-high reset
//            clr   - force the count to zero
//            en    - count this cycle (high for every cycle of a pass)
//            last  - current cycle is the final settle cycle of the pass
// Revision : 1.0  initial release
// ============================================================================
module alu_pass_timer
    import alu_op_sequencer_pkg::*;
#(
    parameter int SETTLE_CYC = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYC - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign last = en && (count_q == LAST_CNT);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            // Wrap on the last cycle so back-to-back passes each get a full count
            count_d = last ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : alu_pass_timer
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Purpose  : Initiator for an 8-bit combinational ALU. Accepts commands on a
//            valid/ready port, drives registered operand/select/carry inputs
//            to the ALU for SETTLE_CYC cycles per pass, samples the ALU
//            result and returns it on a valid/ready response port. Wide
//            commands run as two passes with the low-pass carry-out chained
//            into the high-pass carry-in.
// Ports    : clk, rst                      - clock, sync active-high reset
//            cmd_valid/cmd_ready           - command handshake
//            cmd_a, cmd_b                  - operands (2*DATA_W)
//            cmd_cin, cmd_s, cmd_wide      - carry-in, ALU select, two-pass
//            alu_a, alu_b, alu_cin, alu_s  - registered ALU inputs
//            alu_out, alu_cout             - ALU result and carry-out
//            rsp_valid/rsp_ready           - response handshake
//            rsp_result, rsp_cout          - result (2*DATA_W) and carry
// Revision : 1.0  initial release
// ============================================================================
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int SETTLE_CYC = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2*DATA_W-1:0]   cmd_a,
    input  logic [2*DATA_W-1:0]   cmd_b,
    input  logic                  cmd_cin,
    input  logic [ALU_S_W-1:0]    cmd_s,
    input  logic                  cmd_wide,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic                  alu_cin,
    output logic [ALU_S_W-1:0]    alu_s,
    input  logic [DATA_W-1:0]     alu_out,
    input  logic                  alu_cout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2*DATA_W-1:0]   rsp_result,
    output logic                  rsp_cout
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]              state_q,    state_d;
    // Only the upper operand halves need holding; the lower halves go
    // straight into the ALU input registers on the accepting edge.
    logic [DATA_W-1:0]       a_hi_q,     a_hi_d;
    logic [DATA_W-1:0]       b_hi_q,     b_hi_d;
    logic                    wide_q,     wide_d;
    logic [2*DATA_W-1:0]     res_q,      res_d;
    logic                    carry_q,    carry_d;
    logic [DATA_W-1:0]       alu_a_q,    alu_a_d;
    logic [DATA_W-1:0]       alu_b_q,    alu_b_d;
    logic                    alu_cin_q,  alu_cin_d;
    logic [ALU_S_W-1:0]      alu_s_q,    alu_s_d;

    logic                    timer_clr;
    logic                    timer_en;
    logic                    pass_last;

    // ------------------------------------------------------------------
    // Settle timer
    // ------------------------------------------------------------------
    alu_pass_timer #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_pass_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (timer_clr),
        .en   (timer_en),
        .last (pass_last)
    );

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        a_hi_d    = a_hi_q;
        b_hi_d    = b_hi_q;
        wide_d    = wide_q;
        res_d     = res_q;
        carry_d   = carry_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_cin_d = alu_cin_q;
        alu_s_d   = alu_s_q;
        timer_clr = 1'b0;
        timer_en  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    a_hi_d    = cmd_a[2*DATA_W-1:DATA_W];
                    b_hi_d    = cmd_b[2*DATA_W-1:DATA_W];
                    wide_d    = cmd_wide;
                    // Cleared here so a narrow op returns a zero upper half
                    res_d     = '0;
                    carry_d   = 1'b0;
                    alu_a_d   = cmd_a[DATA_W-1:0];
                    alu_b_d   = cmd_b[DATA_W-1:0];
                    alu_cin_d = cmd_cin;
                    alu_s_d   = cmd_s;
                    timer_clr = 1'b1;
                    state_d   = ST_PASS_LO;
                end
            end

            ST_PASS_LO: begin
                timer_en = 1'b1;
                if (pass_last) begin
                    res_d[DATA_W-1:0] = alu_out;
                    carry_d           = alu_cout;
                    if (wide_q) begin
                        // Chain the low-pass carry straight into the high pass
                        alu_a_d   = a_hi_q;
                        alu_b_d   = b_hi_q;
                        alu_cin_d = alu_cout;
                        state_d   = ST_PASS_HI;
                    end else begin
                        alu_a_d   = '0;
                        alu_b_d   = '0;
                        alu_cin_d = 1'b0;
                        alu_s_d   = '0;
                        state_d   = ST_RESP;
                    end
                end
            end

            ST_PASS_HI: begin
                timer_en = 1'b1;
                if (pass_last) begin
                    res_d[2*DATA_W-1:DATA_W] = alu_out;
                    carry_d   = alu_cout;
                    alu_a_d   = '0;
                    alu_b_d   = '0;
                    alu_cin_d = 1'b0;
                    alu_s_d   = '0;
                    state_d   = ST_RESP;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_hi_q    <= '0;
            b_hi_q    <= '0;
            wide_q    <= 1'b0;
            res_q     <= '0;
            carry_q   <= 1'b0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_cin_q <= 1'b0;
            alu_s_q   <= '0;
        end else begin
            state_q   <= state_d;
            a_hi_q    <= a_hi_d;
            b_hi_q    <= b_hi_d;
            wide_q    <= wide_d;
            res_q     <= res_d;
            carry_q   <= carry_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_cin_q <= alu_cin_d;
            alu_s_q   <= alu_s_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cmd_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = (state_q == ST_RESP);
    // Gated so the response port reads zero whenever no result is offered
    assign rsp_result = rsp_valid ? res_q : '0;
    assign rsp_cout   = rsp_valid & carry_q;

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_cin    = alu_cin_q;
    assign alu_s      = alu_s_q;

endmodule : alu_op_sequencer
`default_nettype wire
